// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if
// Bundles every signal between the memory controller, its two requesters
// (instruction fetch and load/store) and the byte-wide RAM.
//
//   Fetch port     : if_req, if_addr, if_flush -> ; <- if_done, if_data
//   Load/store port: mem_req, mem_we, mem_addr, mem_len, mem_wdata -> ;
//                    <- mem_done, mem_rdata
//   RAM port       : ram_din -> ; <- ram_dout, ram_a, ram_wr
//   Status         : <- busy
//
// Modport slave is the controller view, master is the requester/RAM view.
// -----------------------------------------------------------------------------
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_done;
    logic [31:0]       if_data;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_len;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;

    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;

    logic              busy;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  mem_req, mem_we, mem_addr, mem_len, mem_wdata,
        input  ram_din,
        output if_done, if_data, mem_done, mem_rdata,
        output ram_dout, ram_a, ram_wr, busy
    );

    modport master (
        output if_req, if_addr, if_flush,
        output mem_req, mem_we, mem_addr, mem_len, mem_wdata,
        output ram_din,
        input  if_done, if_data, mem_done, mem_rdata,
        input  ram_dout, ram_a, ram_wr, busy
    );
endinterface

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Arbitrates an instruction-fetch port and a load/store port onto a single
// byte-wide synchronous RAM (read data returns the cycle after its address).
// Multi-byte accesses are serialised one byte per cycle, little-endian.
// Load/store wins over fetch; an in-flight fetch can be flushed.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - mem_ctrl_if.slave: fetch, load/store, RAM and busy signals
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_wdata;
    logic [2:0]        r_n;             // transfer length in bytes (1, 2 or 4)
    logic [2:0]        r_iss;           // bytes issued to the RAM so far
    logic [2:0]        r_rcv;           // bytes received from the RAM so far
    logic              r_is_if;
    logic              r_iss_vld_p0;    // a read address is on ram_a this cycle
    logic              r_rsp_vld_p1;    // ram_din carries a byte this cycle
    logic [31:0]       r_asm;

    logic              r_if_done;
    logic [31:0]       r_if_data;
    logic              r_mem_done;
    logic [31:0]       r_mem_rdata;
    logic [ADDR_W-1:0] r_ram_a;
    logic [7:0]        r_ram_dout;
    logic              r_ram_wr;

    logic [ADDR_W-1:0] w_iss_addr;
    logic              w_iss_more;
    logic [31:0]       w_asm_next;
    logic [7:0]        w_wr_byte;

    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        case (len)
            2'b00:   len_to_n = 3'd1;
            2'b01:   len_to_n = 3'd2;
            default: len_to_n = 3'd4;
        endcase
    endfunction

    // Address arithmetic truncates to ADDR_W, so base+k wraps naturally.
    assign w_iss_addr = r_base + ADDR_W'(r_iss);
    assign w_iss_more = (r_iss < r_n);
    assign w_wr_byte  = r_wdata[{r_iss[1:0], 3'b000} +: 8];

    // Assembly register with the byte arriving this cycle merged in, so the
    // final byte can be published together with the done pulse.
    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[{r_rcv[1:0], 3'b000} +: 8] = bus.ram_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_base       <= '0;
            r_wdata      <= '0;
            r_n          <= '0;
            r_iss        <= '0;
            r_rcv        <= '0;
            r_is_if      <= 1'b0;
            r_iss_vld_p0 <= 1'b0;
            r_rsp_vld_p1 <= 1'b0;
            r_asm        <= '0;
            r_if_done    <= 1'b0;
            r_if_data    <= '0;
            r_mem_done   <= 1'b0;
            r_mem_rdata  <= '0;
            r_ram_a      <= '0;
            r_ram_dout   <= '0;
            r_ram_wr     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_iss        <= '0;
                    r_rcv        <= '0;
                    r_iss_vld_p0 <= 1'b0;
                    r_rsp_vld_p1 <= 1'b0;
                    if (bus.mem_req) begin
                        // First byte goes out straight from the request inputs.
                        r_base   <= bus.mem_addr;
                        r_n      <= len_to_n(bus.mem_len);
                        r_wdata  <= bus.mem_wdata;
                        r_is_if  <= 1'b0;
                        r_iss    <= 3'd1;
                        r_asm    <= '0;
                        r_ram_a  <= bus.mem_addr;
                        if (bus.mem_we) begin
                            r_state    <= MEM_WR;
                            r_ram_wr   <= 1'b1;
                            r_ram_dout <= bus.mem_wdata[7:0];
                        end else begin
                            r_state      <= MEM_RD;
                            r_iss_vld_p0 <= 1'b1;
                        end
                    end else if (bus.if_req && !bus.if_flush) begin
                        r_base       <= bus.if_addr;
                        r_n          <= 3'd4;
                        r_is_if      <= 1'b1;
                        r_iss        <= 3'd1;
                        r_asm        <= '0;
                        r_ram_a      <= bus.if_addr;
                        r_iss_vld_p0 <= 1'b1;
                        r_state      <= IF_RD;
                    end
                end

                IF_RD, MEM_RD: begin
                    if (r_state == IF_RD && bus.if_flush) begin
                        // Abort: bytes still in the RAM pipe are dropped.
                        r_state      <= IDLE;
                        r_ram_a      <= '0;
                        r_iss        <= '0;
                        r_rcv        <= '0;
                        r_iss_vld_p0 <= 1'b0;
                        r_rsp_vld_p1 <= 1'b0;
                    end else begin
                        // Issue stage: one address per cycle until n issued.
                        r_rsp_vld_p1 <= r_iss_vld_p0;
                        if (w_iss_more) begin
                            r_ram_a      <= w_iss_addr;
                            r_iss        <= r_iss + 3'd1;
                            r_iss_vld_p0 <= 1'b1;
                        end else begin
                            r_ram_a      <= '0;
                            r_iss_vld_p0 <= 1'b0;
                        end
                        // Receive stage: one byte per cycle, one cycle behind.
                        if (r_rsp_vld_p1) begin
                            r_asm <= w_asm_next;
                            r_rcv <= r_rcv + 3'd1;
                            if (r_rcv == r_n - 3'd1) begin
                                r_state      <= DONE;
                                r_rsp_vld_p1 <= 1'b0;
                                if (r_is_if) begin
                                    r_if_done <= 1'b1;
                                    r_if_data <= w_asm_next;
                                end else begin
                                    r_mem_done  <= 1'b1;
                                    r_mem_rdata <= w_asm_next;
                                end
                            end
                        end
                    end
                end

                MEM_WR: begin
                    if (w_iss_more) begin
                        r_ram_a    <= w_iss_addr;
                        r_ram_dout <= w_wr_byte;
                        r_ram_wr   <= 1'b1;
                        r_iss      <= r_iss + 3'd1;
                    end else begin
                        r_ram_a    <= '0;
                        r_ram_dout <= '0;
                        r_ram_wr   <= 1'b0;
                        r_mem_done <= 1'b1;
                        r_state    <= DONE;
                    end
                end

                DONE: begin
                    // Single-cycle done pulse; requests are not looked at here.
                    r_if_done  <= 1'b0;
                    r_mem_done <= 1'b0;
                    r_iss      <= '0;
                    r_rcv      <= '0;
                    r_state    <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.if_done   = r_if_done;
    assign bus.if_data   = r_if_data;
    assign bus.mem_done  = r_mem_done;
    assign bus.mem_rdata = r_mem_rdata;
    assign bus.ram_a     = r_ram_a;
    assign bus.ram_dout  = r_ram_dout;
    assign bus.ram_wr    = r_ram_wr;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Bench for mem_ctrl. A byte RAM model answers the controller; a separate
// reference memory holds the architecturally expected contents, and each
// transaction's address sequence, done timing and data are derived from it.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model (aliased on the low 12 address bits) and reference memory.
    logic [7:0] ram     [0:4095];
    logic [7:0] ref_mem [0:4095];

    int          n_vec    = 0;
    int          n_err    = 0;
    logic [31:0] last_if  = '0;
    logic [31:0] last_mem = '0;

    always @(posedge clk) begin
        bus.ram_din <= ram[bus.ram_a[11:0]];
        if (bus.ram_wr === 1'b1) ram[bus.ram_a[11:0]] = bus.ram_dout;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int len2n(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] v);
        ram[a[11:0]]     = v;
        ref_mem[a[11:0]] = v;
    endtask

    // Controller should be idle with outputs parked and data held.
    task automatic idle_check();
        @(negedge clk);
        chk("idle_busy",   {31'b0, bus.busy},     32'd0);
        chk("idle_ram_wr", {31'b0, bus.ram_wr},   32'd0);
        chk("idle_ram_a",  bus.ram_a,             32'd0);
        chk("idle_ifdone", {31'b0, bus.if_done},  32'd0);
        chk("idle_mdone",  {31'b0, bus.mem_done}, 32'd0);
        chk("hold_ifdata", bus.if_data,           last_if);
        chk("hold_mrdata", bus.mem_rdata,         last_mem);
    endtask

    // Called at the negedge just before the accepting edge.
    task automatic watch_read(input bit is_if, input logic [31:0] base, input int n);
        logic [31:0] exp_d;
        logic [31:0] a;
        exp_d = '0;
        for (int k = 0; k < n; k++) begin
            a = base + k;
            exp_d = exp_d | ({24'b0, ref_mem[a[11:0]]} << (8 * k));
        end
        for (int j = 1; j <= n + 2; j++) begin
            @(negedge clk);
            chk("rd_ram_a",  bus.ram_a, (j <= n) ? base + 32'(j - 1) : 32'd0);
            chk("rd_ram_wr", {31'b0, bus.ram_wr}, 32'd0);
            chk("rd_busy",   {31'b0, bus.busy},   32'd1);
            chk("rd_ifdone", {31'b0, bus.if_done},  {31'b0, (is_if && j == n + 2)});
            chk("rd_mdone",  {31'b0, bus.mem_done}, {31'b0, (!is_if && j == n + 2)});
            if (j == 1) begin
                if (is_if) bus.if_addr = $urandom;
                else begin
                    bus.mem_addr  = $urandom;
                    bus.mem_len   = 2'($urandom_range(0, 3));
                    bus.mem_wdata = $urandom;
                end
            end
            if (j == n + 2) begin
                if (is_if) begin
                    chk("if_data", bus.if_data, exp_d);
                    last_if    = exp_d;
                    bus.if_req = 1'b0;
                end else begin
                    chk("mem_rdata", bus.mem_rdata, exp_d);
                    last_mem    = exp_d;
                    bus.mem_req = 1'b0;
                end
            end
        end
    endtask

    task automatic run_fetch(input logic [31:0] addr);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        watch_read(1'b1, addr, 4);
        idle_check();
    endtask

    task automatic run_load(input logic [31:0] addr, input logic [1:0] len);
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = addr;
        bus.mem_len   = len;
        bus.mem_wdata = $urandom;
        watch_read(1'b0, addr, len2n(len));
        idle_check();
    endtask

    task automatic run_store(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] wd);
        int          n;
        logic [31:0] a;
        n = len2n(len);
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_len   = len;
        bus.mem_wdata = wd;
        for (int k = 0; k < n; k++) begin
            a = addr + k;
            ref_mem[a[11:0]] = wd[8*k +: 8];
        end
        for (int j = 1; j <= n + 1; j++) begin
            @(negedge clk);
            chk("wr_ram_a",  bus.ram_a, (j <= n) ? addr + 32'(j - 1) : 32'd0);
            chk("wr_ram_wr", {31'b0, bus.ram_wr}, {31'b0, (j <= n)});
            chk("wr_dout",   {24'b0, bus.ram_dout}, (j <= n) ? {24'b0, wd[8*(j-1) +: 8]} : 32'd0);
            chk("wr_busy",   {31'b0, bus.busy}, 32'd1);
            chk("wr_mdone",  {31'b0, bus.mem_done}, {31'b0, (j == n + 1)});
            chk("wr_ifdone", {31'b0, bus.if_done}, 32'd0);
            if (j == 1) begin
                bus.mem_addr  = $urandom;
                bus.mem_len   = 2'($urandom_range(0, 3));
                bus.mem_wdata = $urandom;
            end
            if (j == n + 1) bus.mem_req = 1'b0;
        end
        idle_check();
    endtask

    initial begin
        logic [31:0] a;
        rst           = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.if_flush  = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_len   = '0;
        bus.mem_wdata = '0;
        for (int i = 0; i < 4096; i++) preload(32'(i), 8'($urandom));

        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h00); preload(32'h103, 8'h00);
        preload(32'h20,  8'hFF);
        preload(32'h42,  8'h5A);
        preload(32'h302, 8'h77);

        repeat (3) @(negedge clk);
        chk("rst_busy",   {31'b0, bus.busy},     32'd0);
        chk("rst_ifdone", {31'b0, bus.if_done},  32'd0);
        chk("rst_mdone",  {31'b0, bus.mem_done}, 32'd0);
        chk("rst_ifdata", bus.if_data,   32'd0);
        chk("rst_mrdata", bus.mem_rdata, 32'd0);
        chk("rst_ram_a",  bus.ram_a,     32'd0);
        chk("rst_dout",   {24'b0, bus.ram_dout}, 32'd0);
        chk("rst_ram_wr", {31'b0, bus.ram_wr},   32'd0);
        rst = 1'b0;

        // Basic fetch.
        run_fetch(32'h100);
        chk("fetch_word", bus.if_data, 32'h0000_0513);

        // Fetch and 1-byte load requested together: load first.
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h100;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'h20;
        bus.mem_len   = 2'b00;
        watch_read(1'b0, 32'h20, 1);
        chk("cont_rdata", bus.mem_rdata, 32'h0000_00FF);
        idle_check();
        watch_read(1'b1, 32'h100, 4);
        idle_check();

        // Halfword store, must not touch 0x42.
        run_store(32'h40, 2'b01, 32'hAABB_CCDD);
        chk("st_0x40", {24'b0, ram[12'h040]}, 32'hDD);
        chk("st_0x41", {24'b0, ram[12'h041]}, 32'hCC);
        chk("st_0x42", {24'b0, ram[12'h042]}, 32'h5A);

        // Flush in cycle 3 of a fetch.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            chk("fl_ram_a", bus.ram_a, 32'h100 + 32'(j - 1));
            chk("fl_ifdone", {31'b0, bus.if_done}, 32'd0);
        end
        bus.if_flush = 1'b1;
        @(negedge clk);
        chk("fl_busy",   {31'b0, bus.busy},    32'd0);
        chk("fl_ram_a0", bus.ram_a,            32'd0);
        chk("fl_ifdone", {31'b0, bus.if_done}, 32'd0);
        bus.if_flush = 1'b0;
        bus.if_req   = 1'b0;
        repeat (3) idle_check();
        run_fetch(32'h100);
        chk("fl_refetch", bus.if_data, 32'h0000_0513);

        // Reset in cycle 2 of a 4-byte store.
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'h300;
        bus.mem_len   = 2'b10;
        bus.mem_wdata = 32'h1122_3344;
        @(negedge clk);
        chk("rs_wr1", {31'b0, bus.ram_wr}, 32'd1);
        @(negedge clk);
        chk("rs_wr2", {31'b0, bus.ram_wr}, 32'd1);
        chk("rs_a2",  bus.ram_a, 32'h301);
        rst = 1'b1;
        @(negedge clk);
        chk("rs_ram_wr", {31'b0, bus.ram_wr},   32'd0);
        chk("rs_mdone",  {31'b0, bus.mem_done}, 32'd0);
        chk("rs_busy",   {31'b0, bus.busy},     32'd0);
        chk("rs_ram_a",  bus.ram_a, 32'd0);
        chk("rs_ifdata", bus.if_data, 32'd0);
        rst         = 1'b0;
        bus.mem_req = 1'b0;
        last_if     = '0;
        last_mem    = '0;
        ref_mem[12'h300] = 8'h44;
        ref_mem[12'h301] = 8'h33;
        repeat (2) idle_check();
        chk("rs_0x302", {24'b0, ram[12'h302]}, 32'h77);

        // Load that wraps past the top of the address space.
        run_load(32'hFFFF_FFFE, 2'b10);

        // Randomised mix of loads, stores and fetches.
        for (int i = 0; i < 40; i++) begin
            int op;
            logic [1:0] len;
            op  = $urandom_range(0, 2);
            len = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            else                           a = 32'h200 + 32'($urandom_range(0, 63));
            case (op)
                0:       run_load(a, len);
                1:       run_store(a, len, $urandom);
                default: run_fetch(a);
            endcase
            if ($urandom_range(0, 1) == 1) idle_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
